// File: rtl/vx_ks_add_sched_pkg.sv
// Shared types and width helpers for the time-multiplexed Kogge-Stone add/sub scheduler.
package vx_ks_add_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int tag_w(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  function automatic int cnt_w(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/vx_ks_add_sched_rr.sv
// Round-robin grant: first valid requester at or after the pointer, with wrap.
module vx_ks_add_sched_rr #(
  parameter int NUM_REQS = 4,
  parameter int TAG_W    = 2
) (
  input  logic [NUM_REQS-1:0] valid_i,
  input  logic [TAG_W-1:0]    ptr_i,
  output logic [NUM_REQS-1:0] grant_o,
  output logic [TAG_W-1:0]    grant_idx_o,
  output logic                any_o
);

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      int j;
      j = (int'(ptr_i) + i) % NUM_REQS;
      if (!any_o && valid_i[j]) begin
        any_o       = 1'b1;
        grant_o[j]  = 1'b1;
        grant_idx_o = TAG_W'(j);
      end
    end
  end

endmodule

// File: rtl/vx_ks_adder.sv
// Purely combinational N-bit Kogge-Stone adder with carry-in and carry-out.
module vx_ks_adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  localparam int LV = (N > 1) ? $clog2(N) : 1;

  always_comb begin : ks
    logic [N-1:0] p0;
    logic [N-1:0] gg;
    logic [N-1:0] pp;
    logic [N-1:0] gn;
    logic [N-1:0] pn;
    logic [N-1:0] c;
    p0 = a_i ^ b_i;
    gg = a_i & b_i;
    pp = p0;
    // Fold the carry-in into bit 0 so the prefix tree yields true carries directly.
    gg[0] = gg[0] | (pp[0] & cin_i);
    for (int l = 0; l < LV; l++) begin
      gn = gg;
      pn = pp;
      for (int i = (1 << l); i < N; i++) begin
        gn[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
        pn[i] = pp[i] & pp[i - (1 << l)];
      end
      gg = gn;
      pp = pn;
    end
    c = {gg[N-2:0], cin_i};
    sum_o  = p0 ^ c;
    cout_o = gg[N-1];
  end

endmodule

// File: rtl/vx_ks_add_sched.sv
// Wide add/sub engine: one shared N-bit adder sequenced chunk by chunk, LS chunk first,
// arbitrated round-robin between requesters.
module vx_ks_add_sched
  import vx_ks_add_sched_pkg::*;
#(
  parameter int N        = 16,
  parameter int CHUNKS   = 4,
  parameter int NUM_REQS = 4,
  localparam int W       = N * CHUNKS,
  localparam int TAG_W   = tag_w(NUM_REQS),
  localparam int CNT_W   = cnt_w(CHUNKS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQS-1:0]   req_valid,
  output logic [NUM_REQS-1:0]   req_ready,
  input  logic [NUM_REQS*W-1:0] req_dataa,
  input  logic [NUM_REQS*W-1:0] req_datab,
  input  logic [NUM_REQS-1:0]   req_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [W-1:0]          rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_ovf,
  output logic [TAG_W-1:0]      rsp_tag
);

  state_e           state_q, state_d;
  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     res_q, res_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [NUM_REQS-1:0] grant;
  logic [TAG_W-1:0]    grant_idx;
  logic                any_valid;
  logic [N-1:0]        a_chunk, b_chunk, sum_chunk;
  logic                add_cout;

  vx_ks_add_sched_rr #(
    .NUM_REQS(NUM_REQS),
    .TAG_W   (TAG_W)
  ) u_rr (
    .valid_i    (req_valid),
    .ptr_i      (rr_ptr_q),
    .grant_o    (grant),
    .grant_idx_o(grant_idx),
    .any_o      (any_valid)
  );

  always_comb begin
    a_chunk = a_q[int'(cnt_q)*N +: N];
    b_chunk = b_q[int'(cnt_q)*N +: N];
  end

  vx_ks_adder #(.N(N)) u_adder (
    .a_i   (a_chunk),
    .b_i   (b_chunk),
    .cin_i (carry_q),
    .sum_o (sum_chunk),
    .cout_o(add_cout)
  );

  assign req_ready = (state_q == ST_IDLE && reset_n) ? grant : '0;
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_sum   = res_q;
  assign rsp_cout  = cout_q;
  assign rsp_ovf   = ovf_q;
  assign rsp_tag   = tag_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    tag_d    = tag_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          a_d      = req_dataa[int'(grant_idx)*W +: W];
          // Subtract is A + ~B + 1; the +1 enters as the first chunk's carry-in.
          b_d      = req_sub[grant_idx] ? ~req_datab[int'(grant_idx)*W +: W]
                                        :  req_datab[int'(grant_idx)*W +: W];
          carry_d  = req_sub[grant_idx];
          tag_d    = grant_idx;
          cnt_d    = '0;
          rr_ptr_d = (int'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + 1'b1;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        res_d[int'(cnt_q)*N +: N] = sum_chunk;
        carry_d = add_cout;
        cnt_d   = cnt_q + 1'b1;
        if (int'(cnt_q) == CHUNKS - 1) begin
          cout_d  = add_cout;
          ovf_d   = add_cout ^ (sum_chunk[N-1] ^ a_q[W-1] ^ b_q[W-1]);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      tag_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      tag_q    <= tag_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_vx_ks_add_sched.sv
// Directed + random scoreboard bench for vx_ks_add_sched (N=16, CHUNKS=4, NUM_REQS=4).
module tb_vx_ks_add_sched;

  localparam int N        = 16;
  localparam int CHUNKS   = 4;
  localparam int NUM_REQS = 4;
  localparam int W        = N * CHUNKS;
  localparam int TAG_W    = 2;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NUM_REQS-1:0]   req_valid;
  logic [NUM_REQS-1:0]   req_ready;
  logic [NUM_REQS*W-1:0] req_dataa;
  logic [NUM_REQS*W-1:0] req_datab;
  logic [NUM_REQS-1:0]   req_sub;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [W-1:0]          rsp_sum;
  logic                  rsp_cout;
  logic                  rsp_ovf;
  logic [TAG_W-1:0]      rsp_tag;

  vx_ks_add_sched #(.N(N), .CHUNKS(CHUNKS), .NUM_REQS(NUM_REQS)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_dataa(req_dataa),
    .req_datab(req_datab),
    .req_sub  (req_sub),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_sum  (rsp_sum),
    .rsp_cout (rsp_cout),
    .rsp_ovf  (rsp_ovf),
    .rsp_tag  (rsp_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   g_tags[$];
  int   g_cycs[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic exp_t model(input int i);
    exp_t         e;
    logic [W-1:0] a, bb;
    logic [W:0]   t;
    a  = req_dataa[i*W +: W];
    bb = req_sub[i] ? ~req_datab[i*W +: W] : req_datab[i*W +: W];
    t  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, req_sub[i]};
    e.tag  = TAG_W'(i);
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] v;
    v = {$urandom, $urandom};
    case ($urandom % 8)
      0: v = '0;
      1: v = '1;
      2: v = {1'b1, {(W-1){1'b0}}};
      3: v = {1'b0, {(W-1){1'b1}}};
      default: ;
    endcase
    return v;
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    req_dataa[i*W +: W] = a;
    req_datab[i*W +: W] = b;
    req_sub[i]          = s;
  endtask

  // One clock: observe the pre-edge handshakes, then advance to 1 time unit past the edge.
  task automatic tick();
    exp_t e;
    #1;
    chk("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
    if (req_ready != '0) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (req_ready[i]) begin
          sb.push_back(model(i));
          g_tags.push_back(i);
          g_cycs.push_back(cyc);
        end
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
        chk("rsp_sum", rsp_sum, e.sum);
        chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
        chk("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("rsp_valid_seen", 64'(rsp_valid), 64'd1);
  endtask

  task automatic drain();
    int n;
    req_valid = '0;
    rsp_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [W-1:0] s_sum;
    logic         s_cout, s_ovf;

    reset_n   = 1'b0;
    req_valid = '0;
    req_dataa = '0;
    req_datab = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_sum", rsp_sum, 64'd0);
    chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    chk("rst_rsp_cout", 64'(rsp_cout), 64'd0);
    chk("rst_rsp_ovf", 64'(rsp_ovf), 64'd0);
    reset_n = 1'b1;
    tick();

    // Req0: all-ones + 1, with latency measurement
    set_req(0, '1, 64'd1, 1'b0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    wait_rsp(n);
    chk("latency", 64'(n + 1), 64'(CHUNKS + 1));
    chk("add_sum", rsp_sum, 64'd0);
    chk("add_cout", 64'(rsp_cout), 64'd1);
    chk("add_ovf", 64'(rsp_ovf), 64'd0);
    chk("add_tag", 64'(rsp_tag), 64'd0);
    tick();

    // Req1: 0 - 1
    set_req(1, 64'd0, 64'd1, 1'b1);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    wait_rsp(n);
    chk("sub0_sum", rsp_sum, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sub0_cout", 64'(rsp_cout), 64'd0);
    chk("sub0_tag", 64'(rsp_tag), 64'd1);
    tick();

    // Req1: most-negative - 1 overflows
    set_req(1, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    wait_rsp(n);
    chk("sub1_sum", rsp_sum, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("sub1_ovf", 64'(rsp_ovf), 64'd1);
    chk("sub1_cout", 64'(rsp_cout), 64'd1);
    tick();

    // Reset during the 2nd BUSY cycle discards the operation
    set_req(0, rnd_w(), rnd_w(), 1'b0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    req_valid = 4'b1111;
    reset_n   = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    reset_n   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("postrst_no_valid", 64'(rsp_valid), 64'd0);
    end
    set_req(3, rnd_w(), rnd_w(), 1'b1);
    req_valid = 4'b1000;
    g_tags.delete();
    tick();
    req_valid = '0;
    chk("postrst_grant_cnt", 64'(g_tags.size()), 64'd1);
    if (g_tags.size() > 0) chk("postrst_grant", 64'(g_tags[0]), 64'd3);
    drain();

    // Round robin with every requester valid
    for (int i = 0; i < NUM_REQS; i++) set_req(i, rnd_w(), rnd_w(), 1'($urandom % 2));
    g_tags.delete();
    g_cycs.delete();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    n = 0;
    while (g_tags.size() < 5 && n < 60) begin
      tick();
      n++;
    end
    req_valid = '0;
    chk("rr_grants", 64'(g_tags.size()), 64'd5);
    for (int i = 0; i < g_tags.size(); i++) begin
      chk("rr_order", 64'(g_tags[i]), 64'(i % NUM_REQS));
      if (i > 0) chk("rr_interval", 64'(g_cycs[i] - g_cycs[i-1]), 64'(CHUNKS + 2));
    end
    drain();

    // Back-pressure in DONE
    set_req(2, rnd_w(), rnd_w(), 1'b0);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    tick();
    req_valid = 4'b1111;
    wait_rsp(n);
    s_sum  = rsp_sum;
    s_cout = rsp_cout;
    s_ovf  = rsp_ovf;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_sum", rsp_sum, s_sum);
      chk("stall_cout", 64'(rsp_cout), 64'(s_cout));
      chk("stall_ovf", 64'(rsp_ovf), 64'(s_ovf));
      chk("stall_tag", 64'(rsp_tag), 64'd2);
      chk("stall_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("after_hs_grant", 64'(req_ready), 64'h8);
    tick();
    req_valid = '0;
    drain();

    // Random traffic with operands changing every cycle
    for (int k = 0; k < 6000; k++) begin
      for (int i = 0; i < NUM_REQS; i++) set_req(i, rnd_w(), rnd_w(), 1'($urandom % 2));
      req_valid = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom % 4) != 0;
      tick();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
